// File: rtl/serial_adder_8.sv
// serial_adder_8: bit-serial LSB-first adder (sum = a + b + cin) behind a start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output o_ovf.
module serial_adder_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_sbit;
  logic             w_cnext;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_acc_next;

  // One full-adder slice on the current LSBs of the operand shift registers.
  assign w_sbit   = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cnext  = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = i_start && (r_state != S_RUN);

  // The accumulator keeps WIDTH-1 bits; on the last RUN cycle the new bit
  // completes the word, so w_acc_next is the full aligned sum.
  assign w_acc_next = {w_sbit, r_acc};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      o_ovf   <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state <= S_RUN;
            o_busy  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            o_ovf   <= 1'b0;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state <= S_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_sum   <= w_acc_next;
            o_cout  <= w_cnext;
`ifdef SERIAL_ADDER_OVF_EN
            // On the last cycle the operand LSBs are the original sign bits.
            o_ovf   <= (r_a[0] == r_b[0]) && (w_sbit != r_a[0]);
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the datapath registers carry no reset; they are always reloaded on
  // an accepted start before any of their contents reach an output.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_carry <= i_cin;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_cnext;
      r_cnt   <= r_cnt + CW'(1);
      r_acc   <= w_acc_next[WIDTH-1:1];
    end
  end

  a_done_single : assert property (@(posedge clk) disable iff (!rst_n) o_done |=> !o_done);
  a_busy_done_excl : assert property (@(posedge clk) disable iff (!rst_n) !(o_busy && o_done));

endmodule

// File: tb/tb_serial_adder_8.sv
// Directed bench for serial_adder_8: scoreboard queue filled at start, drained at done.
module tb_serial_adder_8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_adder_8 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .o_ovf   (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
    logic [W:0] t;
    exp_t e;
    t      = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (ma[W-1] == mb[W-1]) && (t[W-1] != ma[W-1]);
    return e;
  endfunction

  // Called on a negedge: presents operands with start=1 and records the expectation.
  task automatic push_start(input logic [W-1:0] pa, input logic [W-1:0] pb, input logic pc);
    sb.push_back(model(pa, pb, pc));
    a     = pa;
    b     = pb;
    cin   = pc;
    start = 1'b1;
  endtask

  // Waits (bounded) for done after push_start; checks latency, busy length and result.
  task automatic wait_done(input string tag, input int restart_at, input bit chain,
                           input logic [W-1:0] ca, input logic [W-1:0] cb, input logic cc);
    int   lat   = 0;
    int   nbusy = 0;
    bit   got   = 1'b0;
    exp_t e;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
      end
      if (lat == restart_at) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
      end
      if (restart_at > 0 && lat == restart_at + 1) start = 1'b0;
      if (busy) nbusy++;
      if (done) got = 1'b1;
    end
    check({tag, ".done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, ".latency"}, lat, W + 1);
      check({tag, ".busy_cycles"}, nbusy, W);
      check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
      check({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, ".sum"}, 32'(sum), 32'(e.sum));
        check({tag, ".cout"}, 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
`endif
        if (chain) begin
          push_start(ca, cb, cc);
        end else begin
          @(negedge clk);
          check({tag, ".done_drop"}, 32'(done), 32'd0);
          check({tag, ".sum_hold"}, 32'(sum), 32'(e.sum));
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] pa, input logic [W-1:0] pb,
                        input logic pc);
    @(negedge clk);
    push_start(pa, pb, pc);
    wait_done(tag, -1, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int n_done;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.sum", 32'(sum), 32'd0);
    check("rst.cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst.ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;

    run_op("add_0f_01", 8'h0F, 8'h01, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
    run_op("add_00_00_c", 8'h00, 8'h00, 1'b1);
    run_op("inv_55_55", 8'h55, 8'h55, 1'b0);
    run_op("inv_0f_01", 8'h0F, 8'h01, 1'b0);
    run_op("inv_0f_07", 8'h0F, 8'h07, 1'b0);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1);

    // A second start on the 3rd busy cycle must be ignored.
    @(negedge clk);
    push_start(8'h12, 8'h34, 1'b0);
    wait_done("ignore_start", 3, 1'b0, '0, '0, 1'b0);
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("ignore_start.extra_done", n_done, 0);
    check("ignore_start.sum_final", 32'(sum), 32'h46);

    // Reset on the 4th busy cycle discards the operation.
    @(negedge clk);
    a     = 8'hAA;
    b     = 8'h55;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midrst.busy_before", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.sum", 32'(sum), 32'd0);
    check("midrst.cout", 32'(cout), 32'd0);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst.no_done", n_done, 0);
    run_op("after_rst", 8'h3C, 8'hC3, 1'b1);

    // Back-to-back: start presented during the done cycle.
    @(negedge clk);
    push_start(8'h81, 8'h7E, 1'b0);
    wait_done("b2b_1", -1, 1'b1, 8'hA5, 8'h5A, 1'b1);
    wait_done("b2b_2", -1, 1'b0, '0, '0, 1'b0);

`ifdef SERIAL_ADDER_OVF_EN
    run_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0);
    run_op("ovf_80_80", 8'h80, 8'h80, 1'b0);
    run_op("ovf_10_20", 8'h10, 8'h20, 1'b0);
`endif

    for (int k = 0; k < 6; k++) begin
      run_op($sformatf("rand%0d", k), W'($urandom), W'($urandom), 1'($urandom));
    end

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_8.md
# serial_adder_8

Bit-serial ripple adder that recombines a difference with its subtrahend: sum = a + b + cin, computed LSB-first, one bit per clock. It is the companion to the team's 8-bit combinational subtractor. Feeding it the subtractor's S and B reconstructs A, so it serves as the inverse-path datapath in the lab exercise chain. It uses a start/busy/done handshake so it can sit behind a register bank or a test sequencer.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  request; sampled only when the block is not busy
- a  input  WIDTH  operand A, captured on the accepted start edge
- b  input  WIDTH  operand B, captured on the accepted start edge
- cin  input  1  carry-in, captured on the accepted start edge
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle pulse; sum/cout valid from this cycle
- sum  output  WIDTH  result, held until the next accepted start
- cout  output  1  carry out of bit WIDTH-1, held with sum
- ovf  output  1  signed overflow (present only with the macro, see Configuration)

## Operation
- States:
  - IDLE: busy=0, done=0. An accepted start moves to RUN.
  - RUN: busy=1. Stays for WIDTH cycles, then moves to DONE.
  - DONE: done=1, busy=0. Next state is IDLE, or RUN if start=1.
- Capture on accept:
  - shift registers load with a and b.
  - carry register loads with cin.
  - bit counter clears to 0.
  - sum register clears to 0.
- Each RUN cycle:
  - s_i = a0 ^ b0 ^ c
  - c' = majority(a0, b0, c)
  - s_i shifts into the sum MSB while the sum register shifts right.
  - a and b shift right.
  - counter increments.
- After WIDTH RUN cycles, the full sum is aligned and cout = final carry.
- start while busy=1 is ignored; captured operands are never disturbed.
- a, b and cin may change freely after the capture edge.
- Arithmetic is modulo 2^WIDTH; the carry goes only to cout.
- Reset (rst_n=0 at any edge, including mid-RUN):
  - state returns to IDLE;
  - busy, done, sum, cout and ovf all go to 0;
  - the in-flight operation is discarded with no done pulse.

## Timing
- Accept edge E, where start=1 in IDLE or DONE.
- busy=1 from the cycle after E through edge E+WIDTH.
- done=1 during the single cycle after edge E+WIDTH.
- Latency start→done is WIDTH+1 cycles from the cycle start is presented (9 for WIDTH=8).
- Back-to-back: start=1 during the done cycle is accepted, giving throughput of one result per WIDTH+1 cycles.
- sum/cout update only at edge E+WIDTH and stay stable until the next accepted start.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - port ovf exists.
  - ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]), registered with sum.
  - ovf is valid with done and cleared by reset and by an accepted start.
- Undefined:
  - port ovf and its logic are absent.
  - all other behaviour is identical.

## Test plan
- Reset, then a=0x0F, b=0x01, cin=0, start pulse → busy for 8 cycles; done pulse 9 cycles after start; sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; then a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- Inverse check: feed the subtractor result S=0x55 with B=0x55, cin=0 → sum=0xAA (original A); repeat for the pairs 0x0F/0x01 and 0x0F/0x07.
- a=0x12, b=0x34 started, then start with a=0xFF, b=0xFF at the 3rd busy cycle → second start ignored; sum=0x46, single done pulse.
- Start a=0xAA, b=0x55; drive rst_n=0 on the 4th busy cycle → next cycle busy=0, done=0, sum=0, and no done pulse ever appears; a new start afterwards completes normally.
- With SERIAL_ADDER_OVF_EN: 0x7F+0x01 → sum=0x80, ovf=1; 0x80+0x80 → sum=0x00, cout=1, ovf=1; 0x10+0x20 → ovf=0.
